// File: rtl/spi_pkg.sv
// Shared types and sizes for the SPI initiator and its shift registers.
package spi_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        WAIT,
        RECV
    } state_e;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load shift register: shifts towards the MSB, new bit enters at the LSB.
module spi_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         shift_in,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Load has priority over shift; otherwise hold.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_val;
        end else if (shift) begin
            data_d = {data_q[W-2:0], shift_in};
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/spi_master.sv
// Command-level SPI initiator: sends one 10-bit {cmd,data} frame per request
// and, for read-data commands, captures an 8-bit reply from MISO.
module spi_master
    import spi_pkg::*;
#(
    parameter int RD_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_cmd,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_read_q, is_read_d;
    logic                ss_n_q, ss_n_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic                tx_load, tx_shift, rx_shift;
    logic [FRAME_W-1:0]  tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic                unused_bits;

    spi_shift_reg #(.W(FRAME_W)) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tx_load),
        .load_val ({req_cmd, req_data}),
        .shift    (tx_shift),
        .shift_in (1'b0),
        .q        (tx_q)
    );

    spi_shift_reg #(.W(DATA_W)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .load_val ('0),
        .shift    (rx_shift),
        .shift_in (MISO),
        .q        (rx_q)
    );

    // Only the TX MSB is observed; the reply is assembled from the low RX bits plus MISO.
    assign unused_bits = ^{tx_q[FRAME_W-2:0], rx_q[DATA_W-1]};

    // Accept only when idle and out of reset.
    assign req_ready = (state_q == IDLE) && rst_n;

    // Next state, bit counter and next registered outputs. The counter is loaded
    // with (length-1) on each state entry and each state exits on count zero.
    // The first MISO sample is taken on the edge that leaves WAIT, the rest in RECV.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q - CNT_W'(1);
        is_read_d   = is_read_q;
        mosi_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        tx_load     = 1'b0;
        tx_shift    = 1'b0;
        rx_shift    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid && req_ready) begin
                    state_d   = START;
                    tx_load   = 1'b1;
                    is_read_d = (req_cmd == RD_DATA);
                    mosi_d    = req_cmd[1];
                end
            end
            START: begin
                state_d  = SHIFT;
                cnt_d    = CNT_W'(FRAME_W - 1);
                tx_shift = 1'b1;
                mosi_d   = tx_q[FRAME_W-1];
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    tx_shift = 1'b1;
                    mosi_d   = tx_q[FRAME_W-1];
                end else if (is_read_q) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(RD_WAIT - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = RECV;
                    cnt_d    = CNT_W'(DATA_W - 2);
                    rx_shift = 1'b1;
                end
            end
            RECV: begin
                rx_shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = {rx_q[DATA_W-2:0], MISO};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ss_n_d = (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_read_q   <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_read_q   <= is_read_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomised self-checking bench for spi_master against a per-cycle waveform model.
module tb_spi_master;

    localparam int RD_WAIT = 2;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_cmd;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] rsp_model = 8'h00;

    spi_master #(.RD_WAIT(RD_WAIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles between frames: link must stay deselected and quiet.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("idle {ss,mosi,busy,rv,rdy}", {SS_n, MOSI, busy, rsp_valid, req_ready}, 5'b10001);
        end
    endtask

    // One complete frame. The expected waveform after edge Ek is derived from
    // the frame layout: select bit, then {cmd,data} MSB first, then silence;
    // read frames last 18+RD_WAIT cycles with MISO bits consumed at
    // E(11+RD_WAIT)..E(18+RD_WAIT). keep=1 leaves req_valid high with the next
    // request presented; otherwise the request pins are scrambled after acceptance.
    task automatic run_frame(input logic [1:0] cmd, input logic [7:0] data, input logic [7:0] miso_byte,
                             input bit keep, input logic [1:0] nxt_cmd, input logic [7:0] nxt_data);
        bit         rd;
        int         len;
        logic [9:0] frame;
        logic       exp_mosi;
        logic [4:0] exp;
        rd    = (cmd == 2'b11);
        len   = rd ? 18 + RD_WAIT : 11;
        frame = {cmd, data};
        check("ready before request", req_ready, 1);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_data  = data;
        MISO      = 1'($urandom);
        for (int k = 0; k <= len; k++) begin
            step();
            if (k == 0) begin
                if (keep) begin
                    req_cmd  = nxt_cmd;
                    req_data = nxt_data;
                end else begin
                    req_valid = 1'b0;
                    req_cmd   = ~cmd;
                    req_data  = ~data;
                end
            end
            if (k < len) begin
                if (k == 0)       exp_mosi = cmd[1];
                else if (k <= 10) exp_mosi = frame[10-k];
                else              exp_mosi = 1'b0;
                exp = {1'b0, exp_mosi, 1'b1, 1'b0, 1'b0};
            end else begin
                exp = {1'b1, 1'b0, 1'b0, rd, 1'b1};
            end
            check($sformatf("cmd%0d k=%0d {ss,mosi,busy,rv,rdy}", cmd, k),
                  {SS_n, MOSI, busy, rsp_valid, req_ready}, exp);
            if (rd && k >= 10 + RD_WAIT && k <= 17 + RD_WAIT)
                MISO = miso_byte[7-(k-10-RD_WAIT)];
            else
                MISO = 1'($urandom);
        end
        if (rd) rsp_model = miso_byte;
        check("rsp_data", rsp_data, rsp_model);
        $display("frame cmd=%0d data=%02h miso=%02h rsp_data=%02h", cmd, data, miso_byte, rsp_data);
    endtask

    initial begin
        logic [1:0] c;
        logic [7:0] d;
        logic [7:0] m;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_cmd   = 2'b00;
        req_data  = 8'h00;
        MISO      = 1'b0;

        // Reset state while held, then ready on the first cycle after release.
        repeat (3) step();
        check("reset {ss,mosi,busy,rv,rdy}", {SS_n, MOSI, busy, rsp_valid, req_ready}, 5'b10000);
        check("reset rsp_data", rsp_data, 8'h00);
        rst_n = 1'b1;
        step();
        check("post-reset {ss,mosi,busy,rv,rdy}", {SS_n, MOSI, busy, rsp_valid, req_ready}, 5'b10001);

        // Directed: write-address A5, read-data 3C.
        run_frame(2'b00, 8'hA5, 8'h00, 1'b0, 2'b00, 8'h00);
        idle(2);
        run_frame(2'b11, 8'h00, 8'h3C, 1'b0, 2'b00, 8'h00);
        idle(1);

        // Back-to-back with req_valid held high: exactly one SS_n=1 gap cycle.
        run_frame(2'b01, 8'hFF, 8'h00, 1'b1, 2'b10, 8'h12);
        run_frame(2'b10, 8'h12, 8'h00, 1'b0, 2'b00, 8'h00);
        idle(1);

        // Request pins change 55 -> AA after acceptance; frame must still carry 55.
        run_frame(2'b00, 8'h55, 8'h00, 1'b0, 2'b00, 8'h00);
        idle(1);

        // Reset asserted so that it is sampled at E5 of a read-data frame.
        req_valid = 1'b1;
        req_cmd   = 2'b11;
        req_data  = 8'h81;
        step();
        req_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        check("mid-frame reset {ss,mosi,busy,rv,rdy}", {SS_n, MOSI, busy, rsp_valid, req_ready}, 5'b10000);
        rst_n = 1'b1;
        rsp_model = 8'h00;
        step();
        check("after reset release {ss,mosi,busy,rv,rdy}", {SS_n, MOSI, busy, rsp_valid, req_ready}, 5'b10001);
        check("rsp_data cleared", rsp_data, rsp_model);
        idle(2);
        run_frame(2'b01, 8'h3E, 8'h00, 1'b0, 2'b00, 8'h00);

        // Random frames with random idle gaps.
        for (int i = 0; i < 12; i++) begin
            c = 2'($urandom);
            d = 8'($urandom);
            m = 8'($urandom);
            idle($urandom_range(0, 3));
            run_frame(c, d, m, 1'b0, 2'b00, 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
